// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer/FP register file slice.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREG_DEF  = 32;
   localparam int NREAD_DEF = 2;

   function automatic int aw_of(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

   localparam int AW_DEF = $clog2(NREG_DEF);

   typedef enum logic {
      BANK_INT = 1'b0,
      BANK_FP  = 1'b1
   } bank_e;

   typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_multi_if.sv
// Read, jump-register, issue and writeback signals between issue/execute and
// the register file; master is the pipeline side, slave is the register file.
interface regfile_multi_if #(
   parameter int XLEN  = regfile_pkg::XLEN_DEF,
   parameter int NREG  = regfile_pkg::NREG_DEF,
   parameter int NREAD = regfile_pkg::NREAD_DEF
);
   localparam int AW = regfile_pkg::aw_of(NREG);

   logic [NREAD-1:0]      rd_fmode;
   logic [NREAD*AW-1:0]   rd_reg;
   logic [NREAD*XLEN-1:0] rd_data;
   logic [NREAD-1:0]      rd_busy;
   logic [AW-1:0]         jr_reg;
   logic [XLEN-1:0]       jr_data;
   logic                  jr_busy;
   logic                  issue_valid;
   logic                  issue_fmode;
   logic [AW-1:0]         issue_reg;
   logic                  wenable;
   logic                  wfmode;
   logic [AW-1:0]         wreg;
   logic [XLEN-1:0]       wdata;
   logic                  flush;

   modport master (
      output rd_fmode, rd_reg, jr_reg,
      output issue_valid, issue_fmode, issue_reg,
      output wenable, wfmode, wreg, wdata, flush,
      input  rd_data, rd_busy, jr_data, jr_busy
   );

   modport slave (
      input  rd_fmode, rd_reg, jr_reg,
      input  issue_valid, issue_fmode, issue_reg,
      input  wenable, wfmode, wreg, wdata, flush,
      output rd_data, rd_busy, jr_data, jr_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register in each bank, set on
// issue, cleared on writeback, wiped by flush; NLOOK combinational lookups.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREG  = NREG_DEF,
   parameter int NLOOK = NREAD_DEF + 1,
   parameter int AW    = aw_of(NREG)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               issue_valid_i,
   input  logic               issue_fmode_i,
   input  logic [AW-1:0]      issue_reg_i,
   input  logic               wenable_i,
   input  logic               wfmode_i,
   input  logic [AW-1:0]      wreg_i,
   input  logic               flush_i,
   input  logic [NLOOK-1:0]   lk_fmode_i,
   input  logic [NLOOK*AW-1:0] lk_reg_i,
   output logic [NLOOK-1:0]   lk_busy_o
);

   logic [1:0][NREG-1:0] busy_q, busy_d;
   logic                 wr_ok, iss_ok;

   // Integer x0 is hardwired, so it never gets a pending producer.
   assign wr_ok  = wenable_i     && ((bank_e'(wfmode_i)    == BANK_FP) || (wreg_i      != '0));
   assign iss_ok = issue_valid_i && ((bank_e'(issue_fmode_i) == BANK_FP) || (issue_reg_i != '0));

   always_comb begin
      busy_d = busy_q;
      if (wr_ok) busy_d[wfmode_i][wreg_i] = 1'b0;
      if (iss_ok) busy_d[issue_fmode_i][issue_reg_i] = 1'b1;
      if (flush_i) busy_d = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   always_comb begin
      lk_busy_o = '0;
      for (int i = 0; i < NLOOK; i++) begin
         lk_busy_o[i] = busy_q[lk_fmode_i[i]][lk_reg_i[i*AW +: AW]];
      end
   end

endmodule

// File: rtl/regfile_multi.sv
// Integer/FP register file with NREAD read ports, a jump-register port, one
// write port and a busy scoreboard. Define REGFILE_BYPASS_EN for forwarding.
module regfile_multi
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int NREAD = NREAD_DEF
) (
   input  logic           clk,
   input  logic           rstn,
   regfile_multi_if.slave bus
);

   localparam int AW = aw_of(NREG);

   logic [NREG-1:0][XLEN-1:0] int_q, int_d;
   logic [NREG-1:0][XLEN-1:0] fp_q, fp_d;
   logic [NREAD:0]            lk_fmode;
   logic [(NREAD+1)*AW-1:0]   lk_reg;
   logic [NREAD:0]            lk_busy;

   assign lk_fmode = {1'b0, bus.rd_fmode};
   assign lk_reg   = {bus.jr_reg, bus.rd_reg};

   regfile_scoreboard #(
      .NREG  (NREG),
      .NLOOK (NREAD + 1),
      .AW    (AW)
   ) u_scoreboard (
      .clk           (clk),
      .rstn          (rstn),
      .issue_valid_i (bus.issue_valid),
      .issue_fmode_i (bus.issue_fmode),
      .issue_reg_i   (bus.issue_reg),
      .wenable_i     (bus.wenable),
      .wfmode_i      (bus.wfmode),
      .wreg_i        (bus.wreg),
      .flush_i       (bus.flush),
      .lk_fmode_i    (lk_fmode),
      .lk_reg_i      (lk_reg),
      .lk_busy_o     (lk_busy)
   );

   always_comb begin
      int_d = int_q;
      fp_d  = fp_q;
      if (bus.wenable) begin
         if (bank_e'(bus.wfmode) == BANK_FP) fp_d[bus.wreg] = bus.wdata;
         else if (bus.wreg != '0)            int_d[bus.wreg] = bus.wdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         int_q <= '0;
         fp_q  <= '0;
      end else begin
         int_q <= int_d;
         fp_q  <= fp_d;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Gated by rstn so reset forces zero outputs even with a write on the bus.
   function automatic logic wr_hit(input logic fm, input logic [AW-1:0] idx);
      return rstn && bus.wenable && (bus.wfmode == fm) && (bus.wreg == idx) &&
             ((bank_e'(fm) == BANK_FP) || (idx != '0));
   endfunction
`endif

   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      bus.jr_data = '0;
      bus.jr_busy = 1'b0;
      for (int i = 0; i < NREAD; i++) begin
         if (bank_e'(bus.rd_fmode[i]) == BANK_FP)
            bus.rd_data[i*XLEN +: XLEN] = fp_q[bus.rd_reg[i*AW +: AW]];
         else if (bus.rd_reg[i*AW +: AW] != '0)
            bus.rd_data[i*XLEN +: XLEN] = int_q[bus.rd_reg[i*AW +: AW]];
         bus.rd_busy[i] = lk_busy[i];
`ifdef REGFILE_BYPASS_EN
         if (wr_hit(bus.rd_fmode[i], bus.rd_reg[i*AW +: AW])) begin
            bus.rd_data[i*XLEN +: XLEN] = bus.wdata;
            bus.rd_busy[i]              = 1'b0;
         end
`endif
      end
      if (bus.jr_reg != '0) bus.jr_data = int_q[bus.jr_reg];
      bus.jr_busy = lk_busy[NREAD];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit(1'b0, bus.jr_reg)) begin
         bus.jr_data = bus.wdata;
         bus.jr_busy = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_multi.sv
// Directed, table-driven bench for regfile_multi plus hand sequences for
// async reset and same-cycle forwarding (expectations follow REGFILE_BYPASS_EN).
module tb_regfile_multi;
   import regfile_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int NREAD = 2;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   regfile_multi_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) bus ();

   regfile_multi #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        iv;  logic ifm; logic [AW-1:0] ir;
      logic        we;  logic wfm; logic [AW-1:0] wr; logic [XLEN-1:0] wd;
      logic        fl;
      logic        f0;  logic [AW-1:0] r0;
      logic        f1;  logic [AW-1:0] r1;
      logic [AW-1:0] jr;
      logic [XLEN-1:0] e_d0; logic e_b0;
      logic [XLEN-1:0] e_d1; logic e_b1;
      logic [XLEN-1:0] e_jd; logic e_jb;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_ctrl();
      bus.issue_valid = 1'b0; bus.issue_fmode = 1'b0; bus.issue_reg = '0;
      bus.wenable = 1'b0; bus.wfmode = 1'b0; bus.wreg = '0; bus.wdata = '0;
      bus.flush = 1'b0;
   endtask

   task automatic set_reads(input logic f0, input logic [AW-1:0] r0,
                            input logic f1, input logic [AW-1:0] r1,
                            input logic [AW-1:0] jr);
      bus.rd_fmode = {f1, f0};
      bus.rd_reg   = {r1, r0};
      bus.jr_reg   = jr;
   endtask

   task automatic check_all(input string tag,
                            input logic [XLEN-1:0] d0, input logic b0,
                            input logic [XLEN-1:0] d1, input logic b1,
                            input logic [XLEN-1:0] jd, input logic jb);
      chk({tag, " rd_data0"}, bus.rd_data[0 +: XLEN], d0);
      chk({tag, " rd_busy0"}, {31'd0, bus.rd_busy[0]}, {31'd0, b0});
      chk({tag, " rd_data1"}, bus.rd_data[XLEN +: XLEN], d1);
      chk({tag, " rd_busy1"}, {31'd0, bus.rd_busy[1]}, {31'd0, b1});
      chk({tag, " jr_data"}, bus.jr_data, jd);
      chk({tag, " jr_busy"}, {31'd0, bus.jr_busy}, {31'd0, jb});
   endtask

   initial begin
      logic [XLEN-1:0] exp_d;
      logic            exp_b;
      //          name          iv ifm ir  we wfm wr  wd            fl f0 r0  f1 r1  jr  e_d0          b0 e_d1          b1 e_jd          jb
      vecs[0]  = '{"wr_x5",     0, 0,  0,  1, 0,  5,  32'hDEADBEEF, 0, 0, 5,  1, 5,  5,  32'hDEADBEEF, 0, 32'h0,        0, 32'hDEADBEEF, 0};
      vecs[1]  = '{"wr_f5",     0, 0,  0,  1, 1,  5,  32'h3F800000, 0, 0, 5,  1, 5,  5,  32'hDEADBEEF, 0, 32'h3F800000, 0, 32'hDEADBEEF, 0};
      vecs[2]  = '{"x0_wr_iss", 1, 0,  0,  1, 0,  0,  32'h00001234, 0, 0, 0,  1, 0,  0,  32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[3]  = '{"f0_wr",     0, 0,  0,  1, 1,  0,  32'h00000055, 0, 0, 0,  1, 0,  0,  32'h0,        0, 32'h55,       0, 32'h0,        0};
      vecs[4]  = '{"iss_f3",    1, 1,  3,  0, 0,  0,  32'h0,        0, 1, 3,  0, 3,  3,  32'h0,        1, 32'h0,        0, 32'h0,        0};
      vecs[5]  = '{"wr_f3",     0, 0,  0,  1, 1,  3,  32'h00000007, 0, 1, 3,  0, 3,  3,  32'h7,        0, 32'h0,        0, 32'h0,        0};
      vecs[6]  = '{"iss_wr_f3", 1, 1,  3,  1, 1,  3,  32'h00000008, 0, 1, 3,  0, 3,  3,  32'h8,        1, 32'h0,        0, 32'h0,        0};
      vecs[7]  = '{"wr_f3_clr", 0, 0,  0,  1, 1,  3,  32'h00000009, 0, 1, 3,  0, 3,  3,  32'h9,        0, 32'h0,        0, 32'h0,        0};
      vecs[8]  = '{"iss_x7",    1, 0,  7,  0, 0,  0,  32'h0,        0, 0, 7,  0, 8,  7,  32'h0,        1, 32'h0,        0, 32'h0,        1};
      vecs[9]  = '{"iss_x8",    1, 0,  8,  0, 0,  0,  32'h0,        0, 0, 7,  0, 8,  8,  32'h0,        1, 32'h0,        1, 32'h0,        1};
      vecs[10] = '{"flush",     1, 0,  9,  1, 0,  7,  32'h00000077, 1, 0, 7,  0, 9,  8,  32'h77,       0, 32'h0,        0, 32'h0,        0};
      vecs[11] = '{"iss_x9",    1, 0,  9,  0, 0,  0,  32'h0,        0, 1, 9,  0, 9,  9,  32'h0,        0, 32'h0,        1, 32'h0,        1};
      vecs[12] = '{"iss_f9",    1, 1,  9,  0, 0,  0,  32'h0,        0, 1, 9,  0, 9,  9,  32'h0,        1, 32'h0,        1, 32'h0,        1};
      vecs[13] = '{"wr_x9",     0, 0,  0,  1, 0,  9,  32'h000000AB, 0, 1, 9,  0, 9,  9,  32'h0,        1, 32'hAB,       0, 32'hAB,       0};
      vecs[14] = '{"x31_f31",   1, 1,  31, 1, 0,  31, 32'hFFFFFFFF, 0, 0, 31, 1, 31, 31, 32'hFFFFFFFF, 0, 32'h0,        1, 32'hFFFFFFFF, 0};

      clear_ctrl();
      set_reads(1'b0, 5'd5, 1'b1, 5'd5, 5'd5);
      #1;
      check_all("reset", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #16 rstn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         bus.issue_valid = vecs[i].iv; bus.issue_fmode = vecs[i].ifm; bus.issue_reg = vecs[i].ir;
         bus.wenable = vecs[i].we; bus.wfmode = vecs[i].wfm; bus.wreg = vecs[i].wr; bus.wdata = vecs[i].wd;
         bus.flush = vecs[i].fl;
         set_reads(vecs[i].f0, vecs[i].r0, vecs[i].f1, vecs[i].r1, vecs[i].jr);
         @(posedge clk); #1;
         clear_ctrl();
         #1;
         check_all(vecs[i].name, vecs[i].e_d0, vecs[i].e_b0, vecs[i].e_d1, vecs[i].e_b1,
                   vecs[i].e_jd, vecs[i].e_jb);
      end

      // Asynchronous reset mid-operation, with a write presented while held.
      set_reads(1'b0, 5'd31, 1'b1, 5'd9, 5'd31);
      #2 rstn = 1'b0;
      #1;
      check_all("async_rst", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      bus.wenable = 1'b1; bus.wfmode = 1'b0; bus.wreg = 5'd31; bus.wdata = 32'h5;
      bus.issue_valid = 1'b1; bus.issue_fmode = 1'b1; bus.issue_reg = 5'd9;
      @(posedge clk); #1;
      check_all("rst_hold", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      clear_ctrl();
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      check_all("post_rst", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Same-cycle read of a register being written.
      bus.wenable = 1'b1; bus.wfmode = 1'b0; bus.wreg = 5'd4; bus.wdata = 32'd11;
      @(posedge clk); #1;
      clear_ctrl();
      bus.issue_valid = 1'b1; bus.issue_fmode = 1'b0; bus.issue_reg = 5'd4;
      @(posedge clk); #1;
      clear_ctrl();
      set_reads(1'b0, 5'd4, 1'b1, 5'd4, 5'd4);
      #1;
      check_all("x4_pending", 32'd11, 1'b1, 32'h0, 1'b0, 32'd11, 1'b1);
      bus.wenable = 1'b1; bus.wfmode = 1'b0; bus.wreg = 5'd4; bus.wdata = 32'd99;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_d = 32'd99; exp_b = 1'b0;
`else
      exp_d = 32'd11; exp_b = 1'b1;
`endif
      check_all("x4_same_cyc", exp_d, exp_b, 32'h0, 1'b0, exp_d, exp_b);
      @(posedge clk); #1;
      clear_ctrl();
      #1;
      check_all("x4_after", 32'd99, 1'b0, 32'h0, 1'b0, 32'd99, 1'b0);

      // A write to x0 must never be forwarded.
      set_reads(1'b0, 5'd0, 1'b1, 5'd4, 5'd0);
      bus.wenable = 1'b1; bus.wfmode = 1'b0; bus.wreg = 5'd0; bus.wdata = 32'h5;
      #1;
      check_all("x0_same_cyc", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      clear_ctrl();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
